// File: rtl/sap_alu_pkg.sv
// sap_alu_pkg: shared types for the sequential SAP ALU.
// Op encoding, flag bit positions, FSM states, flag packer.
package sap_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_ROL = 3'b111
  } alu_op_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [3:0] pack_flags(
    input logic v,
    input logic n,
    input logic z,
    input logic c
  );
    logic [3:0] f;
    f = '0;
    f[FLAG_V] = v;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/sap_alu_seq_if.sv
// sap_alu_seq_if: sequencer <-> ALU request/result bundle.
// master drives start/op/shamt/ina/inb/Eu; slave returns bus_out/result_q/flags/busy/done.
interface sap_alu_seq_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               start;
  logic [2:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   ina;
  logic [WIDTH-1:0]   inb;
  logic               Eu;
  logic [WIDTH-1:0]   bus_out;
  logic [WIDTH-1:0]   result_q;
  logic [3:0]         flags;
  logic               busy;
  logic               done;

  modport master (
    output start, op, shamt, ina, inb, Eu,
    input  bus_out, result_q, flags, busy, done
  );

  modport slave (
    input  start, op, shamt, ina, inb, Eu,
    output bus_out, result_q, flags, busy, done
  );
endinterface

// File: rtl/sap_alu_shifter.sv
// sap_alu_shifter: serial one-bit-per-step SHL/SHR/ROL engine.
// load latches din/shamt/op; step shifts once; last marks the final step; nxt_d/nxt_c are the post-step value and carry.
import sap_alu_pkg::*;

module sap_alu_shifter #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               load,
  input  logic               step,
  input  alu_op_t            op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic               last,
  output logic [WIDTH-1:0]   nxt_d,
  output logic               nxt_c
);

  logic [WIDTH-1:0]   sreg;
  logic [SHAMT_W-1:0] cnt;
  alu_op_t            mode;

  always_comb begin
    nxt_d = sreg;
    nxt_c = 1'b0;
    unique case (1'b1)
      mode == OP_SHL: begin
        nxt_d = {sreg[WIDTH-2:0], 1'b0};
        nxt_c = sreg[WIDTH-1];
      end
      mode == OP_SHR: begin
        nxt_d = {1'b0, sreg[WIDTH-1:1]};
        nxt_c = sreg[0];
      end
      mode == OP_ROL: begin
        nxt_d = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
        nxt_c = sreg[WIDTH-1];
      end
      default: ;
    endcase
  end

  // Count is nonzero whenever stepping, so 1 marks the final shift.
  assign last = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sreg <= '0;
      cnt  <= '0;
      mode <= OP_ADD;
    end else if (load) begin
      sreg <= din;
      cnt  <= shamt;
      mode <= op;
    end else if (step) begin
      sreg <= nxt_d;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/sap_alu_seq.sv
// sap_alu_seq: registered SAP ALU with start/busy/done and serial shifts.
// Ports: clk, clr_n (async active-low), bus (sap_alu_seq_if.slave).
import sap_alu_pkg::*;

module sap_alu_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          clr_n,
  sap_alu_seq_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             done_q;

  alu_op_t          op_c;
  logic             is_shift;
  logic             is_sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;

  logic             load;
  logic             step;
  logic             fin_one;
  logic             fin_sh;
  logic             sh_last;
  logic [WIDTH-1:0] sh_d;
  logic             sh_c;

  assign op_c     = alu_op_t'(bus.op);
  assign is_shift = (op_c == OP_SHL) ||
                    (op_c == OP_SHR) ||
                    (op_c == OP_ROL);
  assign is_sub   = (op_c == OP_SUB);

  // SUB reuses the adder as ina + ~inb + 1.
  always_comb begin
    bx  = is_sub ? ~bus.inb : bus.inb;
    sum = {1'b0, bus.ina} + {1'b0, bx} +
          {{WIDTH{1'b0}}, is_sub};
  end

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (1'b1)
      op_c == OP_ADD,
      op_c == OP_SUB: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.ina[WIDTH-1] == bx[WIDTH-1]) &&
                (sum[WIDTH-1] != bus.ina[WIDTH-1]);
      end
      op_c == OP_AND: alu_r = bus.ina & bus.inb;
      op_c == OP_OR:  alu_r = bus.ina | bus.inb;
      op_c == OP_XOR: alu_r = bus.ina ^ bus.inb;
      is_shift:       alu_r = bus.ina;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin_one = 1'b0;
    fin_sh  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_shift && (bus.shamt != '0)) begin
            load    = 1'b1;
            state_d = SHIFT;
          end else begin
            fin_one = 1'b1;
          end
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (sh_last) begin
          fin_sh  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sap_alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk   (clk),
    .clr_n (clr_n),
    .load  (load),
    .step  (step),
    .op    (op_c),
    .shamt (bus.shamt),
    .din   (bus.ina),
    .last  (sh_last),
    .nxt_d (sh_d),
    .nxt_c (sh_c)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= fin_one | fin_sh;
      if (fin_one) begin
        result_q <= alu_r;
        flags_q  <= pack_flags(alu_v, alu_r[WIDTH-1],
                               alu_r == '0, alu_c);
      end else if (fin_sh) begin
        result_q <= sh_d;
        flags_q  <= pack_flags(1'b0, sh_d[WIDTH-1],
                               sh_d == '0, sh_c);
      end
    end
  end

  assign bus.result_q = result_q;
  assign bus.flags    = flags_q;
  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.bus_out  = bus.Eu ? result_q : '0;

endmodule

// File: tb/tb_sap_alu_seq.sv
// tb_sap_alu_seq: self-checking bench for sap_alu_seq (WIDTH=8).
// Arithmetic reference model plus directed and random scenarios.
module tb_sap_alu_seq;

  logic clk;
  logic clr_n;
  int   checks;
  int   passed;

  sap_alu_seq_if #(.WIDTH(8)) bif ();

  sap_alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {V,N,Z,C, result} from plain integer arithmetic.
  function automatic logic [11:0] model(
    input logic [2:0] o,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] s
  );
    int ai, bi, sa, sb, si, r, c, v;
    logic [7:0] rr;
    ai = int'(a);
    bi = int'(b);
    si = int'(s);
    sa = (ai > 127) ? ai - 256 : ai;
    sb = (bi > 127) ? bi - 256 : bi;
    r = 0; c = 0; v = 0;
    case (o)
      3'd0: begin
        r = ai + bi;
        c = (r > 255) ? 1 : 0;
        v = (sa + sb > 127 || sa + sb < -128) ? 1 : 0;
        r = r % 256;
      end
      3'd1: begin
        r = (ai - bi + 256) % 256;
        c = (ai >= bi) ? 1 : 0;
        v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0;
      end
      3'd2: r = ai & bi;
      3'd3: r = ai | bi;
      3'd4: r = ai ^ bi;
      3'd5: begin
        r = (ai << si) % 256;
        c = (si == 0) ? 0 : (ai >> (8 - si)) % 2;
      end
      3'd6: begin
        r = ai >> si;
        c = (si == 0) ? 0 : (ai >> (si - 1)) % 2;
      end
      default: begin
        r = ((ai << si) | (ai >> (8 - si))) % 256;
        c = (si == 0) ? 0 : r % 2;
      end
    endcase
    rr = r[7:0];
    return {v != 0, rr[7], rr == 8'h00, c != 0, rr};
  endfunction

  // Issues one op, scrambles operands, checks latency/busy/result/flags.
  task automatic run_op(
    input logic [2:0] o,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [2:0] s,
    input string      tag
  );
    logic [11:0] m;
    int n, cyc, bc;
    m = model(o, a, b, s);
    n = (o >= 3'd5) ? int'(s) : 0;
    bif.op = o; bif.ina = a; bif.inb = b;
    bif.shamt = s; bif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.start = 1'b0;
    bif.op = 3'($urandom);
    bif.ina = 8'($urandom);
    bif.inb = 8'($urandom);
    bif.shamt = 3'($urandom);
    cyc = 0; bc = 0;
    while (!bif.done && cyc < 20) begin
      if (bif.busy) bc++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== n)
      $display("FAIL %s latency got=%0d exp=%0d", tag, cyc, n);
    else passed++;
    checks++;
    if (bc !== n)
      $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, bc, n);
    else passed++;
    checks++;
    if (bif.result_q !== m[7:0])
      $display("FAIL %s result got=%h exp=%h", tag, bif.result_q, m[7:0]);
    else passed++;
    checks++;
    if (bif.flags !== m[11:8])
      $display("FAIL %s flags got=%b exp=%b", tag, bif.flags, m[11:8]);
    else passed++;
    @(negedge clk);
    checks++;
    if (bif.done !== 1'b0 || bif.busy !== 1'b0)
      $display("FAIL %s done_pulse got done=%b busy=%b exp 0 0",
               tag, bif.done, bif.busy);
    else passed++;
  endtask

  task automatic test_reset();
    bif.start = 0; bif.op = 0; bif.shamt = 0;
    bif.ina = 0; bif.inb = 0; bif.Eu = 1;
    clr_n = 1'b0;
    #1;
    checks++;
    if ({bif.result_q, bif.flags, bif.busy, bif.done} !== 14'd0)
      $display("FAIL reset got r=%h f=%b b=%b d=%b exp 0",
               bif.result_q, bif.flags, bif.busy, bif.done);
    else passed++;
    checks++;
    if (bif.bus_out !== 8'h00)
      $display("FAIL reset_bus got=%h exp=00", bif.bus_out);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith();
    run_op(3'd0, 8'h7F, 8'h01, 3'd0, "add_ovf");
    checks++;
    if (bif.result_q !== 8'h80 || bif.flags !== 4'b1100)
      $display("FAIL add_ovf_const got=%h/%b exp=80/1100",
               bif.result_q, bif.flags);
    else passed++;
    run_op(3'd1, 8'h05, 8'h05, 3'd0, "sub_zero");
    checks++;
    if (bif.result_q !== 8'h00 || bif.flags !== 4'b0011)
      $display("FAIL sub_zero_const got=%h/%b exp=00/0011",
               bif.result_q, bif.flags);
    else passed++;
    run_op(3'd1, 8'h03, 8'h05, 3'd0, "sub_borrow");
    checks++;
    if (bif.result_q !== 8'hFE || bif.flags !== 4'b0100)
      $display("FAIL sub_borrow_const got=%h/%b exp=FE/0100",
               bif.result_q, bif.flags);
    else passed++;
  endtask

  task automatic test_shift();
    run_op(3'd5, 8'h81, 8'h00, 3'd3, "shl3");
    checks++;
    if (bif.result_q !== 8'h08 || bif.flags[0] !== 1'b0)
      $display("FAIL shl3_const got=%h/%b exp=08 C=0",
               bif.result_q, bif.flags);
    else passed++;
    run_op(3'd7, 8'h81, 8'h00, 3'd1, "rol1");
    checks++;
    if (bif.result_q !== 8'h03 || bif.flags[0] !== 1'b1)
      $display("FAIL rol1_const got=%h/%b exp=03 C=1",
               bif.result_q, bif.flags);
    else passed++;
  endtask

  task automatic test_busy_restart();
    int dn, bc;
    bif.op = 3'd6; bif.ina = 8'hF0; bif.inb = 8'h11;
    bif.shamt = 3'd7; bif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.start = 1'b0;
    dn = 0; bc = 0;
    for (int i = 0; i < 12; i++) begin
      if (bif.busy) bc++;
      if (bif.done) dn++;
      if (i == 2) begin
        bif.op = 3'd0; bif.ina = 8'h22; bif.start = 1'b1;
      end else begin
        bif.start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (dn !== 1)
      $display("FAIL restart_done_count got=%0d exp=1", dn);
    else passed++;
    checks++;
    if (bc !== 7)
      $display("FAIL restart_busy got=%0d exp=7", bc);
    else passed++;
    checks++;
    if (bif.result_q !== 8'h01 || bif.flags !== 4'b0001)
      $display("FAIL restart_result got=%h/%b exp=01/0001",
               bif.result_q, bif.flags);
    else passed++;
  endtask

  task automatic test_clear_midshift();
    int dn;
    logic was_busy;
    run_op(3'd0, 8'h7F, 8'h01, 3'd0, "pre_clr");
    bif.op = 3'd5; bif.ina = 8'h81; bif.shamt = 3'd5;
    bif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.start = 1'b0;
    @(negedge clk);
    was_busy = bif.busy;
    clr_n = 1'b0;
    #1;
    checks++;
    if (was_busy !== 1'b1 ||
        {bif.result_q, bif.flags, bif.busy, bif.done} !== 14'd0)
      $display("FAIL clr_abort got busy_before=%b r=%h f=%b b=%b d=%b exp 1 0",
               was_busy, bif.result_q, bif.flags, bif.busy, bif.done);
    else passed++;
    @(negedge clk);
    clr_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bif.done || bif.busy) dn++;
    end
    checks++;
    if (dn !== 0)
      $display("FAIL clr_no_done got=%0d exp=0", dn);
    else passed++;
    run_op(3'd4, 8'hAA, 8'hFF, 3'd0, "xor_after_clr");
    checks++;
    if (bif.result_q !== 8'h55 || bif.flags !== 4'b0000)
      $display("FAIL xor_const got=%h/%b exp=55/0000",
               bif.result_q, bif.flags);
    else passed++;
  endtask

  task automatic test_bus_gate();
    bif.Eu = 1'b1;
    #1;
    checks++;
    if (bif.bus_out !== 8'h55)
      $display("FAIL eu_on got=%h exp=55", bif.bus_out);
    else passed++;
    bif.Eu = 1'b0;
    #1;
    checks++;
    if (bif.bus_out !== 8'h00)
      $display("FAIL eu_off got=%h exp=00", bif.bus_out);
    else passed++;
    @(negedge clk);
    bif.Eu = 1'b1;
    @(negedge clk);
    checks++;
    if (bif.result_q !== 8'h55 || bif.bus_out !== 8'h55 || bif.done !== 1'b0)
      $display("FAIL eu_hold got r=%h bus=%h d=%b exp 55 55 0",
               bif.result_q, bif.bus_out, bif.done);
    else passed++;
    run_op(3'd6, 8'h3C, 8'h00, 3'd0, "shr0");
    checks++;
    if (bif.result_q !== 8'h3C || bif.flags[0] !== 1'b0)
      $display("FAIL shr0_const got=%h/%b exp=3C C=0",
               bif.result_q, bif.flags);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] m;
    logic [2:0]  o;
    bif.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 7));
      bif.op = o;
      bif.ina = 8'($urandom);
      bif.inb = 8'($urandom);
      bif.shamt = (o >= 3'd5) ? 3'd0 : 3'($urandom);
      m = model(o, bif.ina, bif.inb, bif.shamt);
      @(negedge clk);
      checks++;
      if (bif.done !== 1'b1 || bif.busy !== 1'b0 ||
          bif.result_q !== m[7:0] || bif.flags !== m[11:8])
        $display("FAIL b2b_%0d got d=%b b=%b r=%h f=%b exp 1 0 %h %b",
                 i, bif.done, bif.busy, bif.result_q, bif.flags,
                 m[7:0], m[11:8]);
      else passed++;
    end
    bif.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_op(3'($urandom), 8'($urandom), 8'($urandom),
             3'($urandom), $sformatf("rnd%0d", i));
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    clr_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_arith();
    test_shift();
    test_busy_restart();
    test_clear_midshift();
    test_bus_gate();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sap_alu_seq.md
# sap_alu_seq

Parametrised, sequential successor to the SAP-1 combinational add/subtract ALU. It adds registered result and flags, a start/busy/done handshake, logic operations, and multi-cycle serial shifts and rotates. It sits between the accumulator/B registers and the W bus, and is driven by the controller-sequencer. Operands are sampled on start, so the accumulator and B registers may change while an operation is in progress.

## Interface
Parameters:
- WIDTH, 8, datapath width; power of two, ≥4
- SHAMT_W, $clog2(WIDTH), shift-amount width

Ports:
- clk  in  1  system clock; all state on rising edge
- clr_n  in  1  asynchronous active-low clear
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 ROL
- shamt  in  SHAMT_W  shift/rotate count; ignored for non-shift ops
- ina  in  WIDTH  operand A (accumulator)
- inb  in  WIDTH  operand B (B register)
- Eu  in  1  bus enable: bus_out = Eu ? result_q : 0
- bus_out  out  WIDTH  gated result to W bus
- result_q  out  WIDTH  registered result
- flags  out  4  {V, N, Z, C}, registered
- busy  out  1  shift in progress
- done  out  1  one-cycle completion pulse

## Operation
- Reset values (clr_n=0, asynchronous): result_q=0, flags=0, busy=0, done=0, state=IDLE, internal operand/count registers=0.
- States:
  - IDLE → IDLE on a single-cycle op.
  - IDLE → SHIFT on a shift op with shamt≠0.
  - SHIFT → IDLE when the count reaches 0.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, and shifts with shamt=0.
- ADD: {C,result} = ina + inb, computed at WIDTH+1 bits.
- SUB: result = ina − inb (computed as ina + ~inb + 1); C = 1 means no borrow (ina ≥ inb unsigned).
- ADD/SUB V: signed two's-complement overflow.
- Logic ops and shamt=0 shifts: C=0, V=0. A shamt=0 shift gives result=ina.
- All ops: Z = (result==0), N = result[WIDTH-1].
- Shifts: one bit per cycle.
  - C = last bit shifted out.
  - SHL fills with 0, SHR fills with 0.
  - ROL wraps the MSB into the LSB; C = the bit wrapped.
  - V=0.
- result_q and flags update only on completion; they hold between operations.
- start while busy=1 is ignored; no queueing.
- start is ignored in the same cycle done=1 only if busy=1. In IDLE it is always accepted, including back-to-back every cycle.
- Eu has no effect on state. bus_out is purely combinational from Eu and result_q.

## Timing
- Single-cycle op with start sampled at edge k: result_q and flags valid after edge k; done=1 for the cycle after edge k; busy stays 0.
- Shift with shamt=n≥1 and start at edge k:
  - Edge k: latch ina, count=n, busy=1.
  - Edges k+1 … k+n: one shift each, count decrements.
  - Edge k+n: result_q and flags written, busy=0, done=1 for one cycle.
  - busy is high for exactly n cycles.
- Next start is accepted at edge k+n+1 or later; for single-cycle ops, at edge k+1.
- clr_n asserted mid-shift: immediate abort to reset values; no done pulse.
- Operand changes after edge k have no effect on the in-flight operation.

## Structure
- Package sap_alu_pkg holds:
  - op encoding enum alu_op_t
  - flag bit indices FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3
  - state enum {IDLE, SHIFT}
- Sub-module sap_alu_shifter holds the serial shift register, down-counter and carry capture for SHL/SHR/ROL, with load/step/last handshake to the top.
- Top level holds the FSM, the combinational add/sub/logic unit, result/flag registers and the bus gate.

## Test plan
All scenarios use WIDTH=8.
- ADD ina=0x7F, inb=0x01: result_q=0x80, V=1, N=1, Z=0, C=0; done pulses one cycle after start; busy never rises.
- SUB 0x05−0x05: result 0x00, Z=1, C=1. Then SUB 0x03−0x05: result 0xFE, C=0, N=1, V=0.
- SHL 0x81 shamt=3: busy high 3 cycles, result 0x08, C=0. Then ROL 0x81 shamt=1: result 0x03, C=1, busy high 1 cycle.
- SHR shamt=7 on 0xF0 with start re-pulsed while busy: second start ignored; single done; result 0x01, C=1.
- clr_n pulsed low during SHL shamt=5: all outputs 0 immediately and no done; a following XOR 0xAA^0xFF gives 0x55 with Z=0, C=0.
- Eu toggling with result_q=0x55: bus_out follows 0x55/0x00 combinationally, result_q unchanged. SHR shamt=0 on 0x3C gives result 0x3C, C=0, single-cycle done.
